joypad_poller: RTL and testbench
================================

Name: joypad_poller

Overview:
- Serial front end for a standard NES controller (4021 shift register).
- Generates the latch and clock waveforms, shifts in 8 button bits, and filters them across successive polls.
- Drives the debounced-ready 8-bit active-high JOYPAD bus consumed by nes_top / rp2a03.
- Sits between the controller connector pins and nes_top's JOYPAD input.

Parameters:
- TICK_DIV, 600: clk_in cycles per half-period T of the serial clock (6 us at 100 MHz). Must be ≥ 2.
- POLL_DIV, 1666667: clk_in cycles between poll starts (~60 Hz). Must be > 17*TICK_DIV.
- FILTER_CNT, 2: consecutive identical polls required before buttons_out updates. Range 1..7.

Ports:
- clk_in, in, 1: system clock (100 MHz).
- nres_in, in, 1: reset, asynchronous, active-low.
- jp_data_in, in, 1: controller serial data, active-low (0 = pressed). Double-flop synchronised inside.
- poll_req_in, in, 1: one-cycle request for an immediate poll.
- jp_latch_out, out, 1: controller latch, active-high.
- jp_clk_out, out, 1: controller shift clock; idles low.
- buttons_out, out, 8: filtered buttons, active-high.
  - Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- busy_out, out, 1: high while a poll is in progress.
- done_out, out, 1: one-cycle pulse after each poll's final sample.
- changed_out, out, 1: one-cycle pulse when buttons_out changes value.

Behaviour:
- Reset (nres_in=0, async): all outputs 0. State IDLE. Interval counter, tick counter, bit index, shift register and match_cnt cleared. prev_raw = 0.
- Interval counter runs continuously.
  - When it reaches POLL_DIV-1 in IDLE, it wraps to 0 and a poll starts next cycle.
  - First automatic poll begins POLL_DIV cycles after reset release.
- poll_req_in while IDLE: poll starts next cycle and the interval counter is cleared. poll_req_in while busy is ignored (not queued).
- Interval expiry coinciding with an active poll: that poll start is skipped.
- Timing is quantised to T = TICK_DIV cycles via the tick counter.
- States:
  - IDLE: latch=0, clk=0, busy=0.
  - LATCH: latch=1 for 2T; busy=1. Then go to BIT0.
  - BIT0: latch=0, clk=0 for T. Sample the synchronised data into shift[0] on the last cycle. Set idx=1, go to CLKH.
  - CLKH: clk=1 for T, then go to CLKL.
  - CLKL: clk=0 for T. Sample into shift[idx] on the last cycle.
    - If idx=7, go to DONE; otherwise idx++ and go to CLKH.
  - DONE: single cycle. done_out=1, filter update (below), then IDLE.
- Total poll length: 2T + T + 14T = 17T cycles, plus 1 DONE cycle.
- Filter, evaluated in DONE on raw = ~shift:
  - If raw == prev_raw: match_cnt = min(match_cnt+1, FILTER_CNT).
  - Otherwise: prev_raw = raw, match_cnt = 1.
  - If the updated match_cnt == FILTER_CNT and raw != buttons_out: on the next cycle buttons_out <= raw and changed_out pulses 1 cycle.
  - Latency from final sample to buttons_out update: 2 cycles.
- Reset mid-poll: outputs drop to 0 immediately. No partial result is published. The next poll follows normal post-reset timing.
- Disconnected controller (data floats high) reads all-released: buttons_out = 0x00.

Test Plan (TICK_DIV=4, POLL_DIV=200, FILTER_CNT=2 unless stated):
- Reset check: after release, all outputs are 0. First latch rises at cycle 200. Latch stays high exactly 8 cycles. Exactly 7 clk pulses, each 4 high / 4 low. busy spans 68 cycles.
- Constant pattern: controller model returns A, Start and Left pressed (data low on bits 0, 3, 6) for 2 polls.
  - Poll 1: buttons_out stays 0x00; done_out pulses.
  - Poll 2: buttons_out=0x49 and changed_out pulses once.
  - Poll 3 (same pattern): no changed_out.
- Glitch rejection: held 0x49, then one poll reads 0x48, then 0x49 again → buttons_out remains 0x49 and changed_out never fires.
- poll_req_in at cycle 50: latch rises at cycle 51 and the next auto poll starts 200 cycles later. A second poll_req_in at cycle 60 (busy) has no effect.
- Reset mid-poll: assert nres_in low during CLKH of bit 4 → jp_clk_out and busy_out fall within the same cycle and buttons_out=0x00. Restart timing matches the reset check.
- FILTER_CNT=1: single poll of 0x81 (A + Right) → buttons_out=0x81 two cycles after the final sample.

Source files
------------

// File: rtl/joypad_poller.sv
// joypad_poller: NES controller (4021) serial front end.
// Generates latch/clock waveforms, shifts in 8 active-low button bits,
// and publishes them only after FILTER_CNT identical consecutive polls.
module joypad_poller #(
    parameter int TICK_DIV   = 600,
    parameter int POLL_DIV   = 1666667,
    parameter int FILTER_CNT = 2
) (
    input  logic       clk_in,
    input  logic       nres_in,
    input  logic       jp_data_in,
    input  logic       poll_req_in,
    output logic       jp_latch_out,
    output logic       jp_clk_out,
    output logic [7:0] buttons_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       changed_out
);

    localparam int IW = $clog2(POLL_DIV);
    localparam int TW = $clog2(2 * TICK_DIV);
    localparam logic [IW-1:0] INT_LAST = IW'(POLL_DIV - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T2_LAST  = TW'(2 * TICK_DIV - 1);
    localparam logic [2:0]    FCNT     = 3'(FILTER_CNT);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_BIT0, S_CLKH, S_CLKL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   int_q, int_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      match_q, match_d;
    logic [7:0]      prev_q, prev_d;
    logic [7:0]      btn_q, btn_d;
    logic            chg_q, chg_d;
    logic [1:0]      sync_q;

    logic            data_s;
    logic            int_wrap;
    logic            tick_last;
    logic [7:0]      raw;

    assign data_s = sync_q[1];
    assign raw    = ~shift_q;

    // Two-flop synchroniser; resets to "released" so a floating line reads idle.
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], jp_data_in};
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            state_q <= S_IDLE;
            int_q   <= '0;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            match_q <= '0;
            prev_q  <= '0;
            btn_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            match_q <= match_d;
            prev_q  <= prev_d;
            btn_q   <= btn_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state: interval timer, phase timing, bit capture and filter update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        match_d  = match_q;
        prev_d   = prev_q;
        btn_d    = btn_q;
        chg_d    = 1'b0;

        // Interval counter free-runs; an expiry outside IDLE is simply dropped.
        int_wrap = (int_q == INT_LAST);
        int_d    = int_wrap ? '0 : int_q + IW'(1);

        // The latch phase is two ticks long, every other phase one tick.
        tick_last = (state_q == S_LATCH) ? (tick_q == T2_LAST) : (tick_q == T_LAST);
        tick_d    = tick_last ? '0 : tick_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (poll_req_in) begin
                    state_d = S_LATCH;
                    int_d   = '0;
                end else if (int_wrap) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (tick_last) state_d = S_BIT0;
            end
            S_BIT0: begin
                // Button A is presented by the 4021 as soon as latch drops.
                if (tick_last) begin
                    shift_d[0] = data_s;
                    idx_d      = 3'd1;
                    state_d    = S_CLKH;
                end
            end
            S_CLKH: begin
                if (tick_last) state_d = S_CLKL;
            end
            S_CLKL: begin
                if (tick_last) begin
                    shift_d[idx_q] = data_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_CLKH;
                    end
                end
            end
            S_DONE: begin
                tick_d  = '0;
                state_d = S_IDLE;
                if (raw == prev_q) begin
                    match_d = (match_q == FCNT) ? FCNT : match_q + 3'd1;
                end else begin
                    prev_d  = raw;
                    match_d = 3'd1;
                end
                if (match_d == FCNT && raw != btn_q) begin
                    btn_d = raw;
                    chg_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin and status outputs decode directly from state so reset drops them at once.
    always_comb begin
        jp_latch_out = (state_q == S_LATCH);
        jp_clk_out   = (state_q == S_CLKH);
        busy_out     = (state_q == S_LATCH) || (state_q == S_BIT0) ||
                       (state_q == S_CLKH)  || (state_q == S_CLKL);
        done_out     = (state_q == S_DONE);
        buttons_out  = btn_q;
        changed_out  = chg_q;
    end

endmodule

// File: tb/tb_joypad_poller.sv
// Bench for joypad_poller: controller shift-register model, history-based
// filter reference, directed timing steps and randomized patterns.
module tb_joypad_poller;

    localparam int TD = 4;
    localparam int PD = 200;
    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       nres;
    logic       poll_req;
    logic       data1, data2;
    logic       latch1, jclk1, busy1, done1, chg1;
    logic       latch2, jclk2, busy2, done2, chg2;
    logic [7:0] btn1, btn2;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    joypad_poller #(.TICK_DIV(TD), .POLL_DIV(PD), .FILTER_CNT(FC)) dut1 (
        .clk_in(clk), .nres_in(nres), .jp_data_in(data1), .poll_req_in(poll_req),
        .jp_latch_out(latch1), .jp_clk_out(jclk1), .buttons_out(btn1),
        .busy_out(busy1), .done_out(done1), .changed_out(chg1)
    );

    joypad_poller #(.TICK_DIV(TD), .POLL_DIV(PD), .FILTER_CNT(1)) dut2 (
        .clk_in(clk), .nres_in(nres), .jp_data_in(data2), .poll_req_in(1'b0),
        .jp_latch_out(latch2), .jp_clk_out(jclk2), .buttons_out(btn2),
        .busy_out(busy2), .done_out(done2), .changed_out(chg2)
    );

    // 4021 model: latch snapshots the pressed set, each clk rise advances a bit.
    logic [7:0] pat1 = 8'h00, snap1 = 8'h00;
    logic [7:0] pat2 = 8'h00, snap2 = 8'h00;
    int ptr1 = 8, ptr2 = 8;

    always @(posedge latch1 or posedge jclk1)
        if (latch1) begin snap1 <= pat1; ptr1 <= 0; end
        else ptr1 <= ptr1 + 1;
    always @(posedge latch2 or posedge jclk2)
        if (latch2) begin snap2 <= pat2; ptr2 <= 0; end
        else ptr2 <= ptr2 + 1;

    assign data1 = (ptr1 < 8) ? ~snap1[ptr1[2:0]] : 1'b1;
    assign data2 = (ptr2 < 8) ? ~snap2[ptr2[2:0]] : 1'b1;

    // Reference: published value changes once the last FC polls all agree.
    logic [7:0] hist[$];
    logic [7:0] m_btn = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        while (latch1 !== 1'b1 && n < 1000) begin step(); n++; end
    endtask

    // Walks one poll from latch rise to the DONE cycle, tallying waveform widths.
    task automatic measure(output int b, output int l, output int h, output int lo, output int p);
        logic pc;
        b = 0; l = 0; h = 0; lo = 0; p = 0; pc = 1'b0;
        while (busy1 === 1'b1 && b < 200) begin
            b++;
            if (latch1) l++;
            if (jclk1) h++;
            if (!jclk1 && !latch1) lo++;
            if (jclk1 && !pc) p++;
            pc = jclk1;
            step();
        end
    endtask

    task automatic poll_check(input string tag, input logic [7:0] pat);
        int n;
        logic [7:0] nb;
        bit same;
        pat1 = pat;
        n = 0;
        while (done1 !== 1'b1 && n < 2000) begin step(); n++; end
        chk({tag, "_done"}, 32'(done1), 32'd1);
        hist.push_back(pat);
        if (hist.size() > FC) void'(hist.pop_front());
        nb = m_btn;
        if (hist.size() == FC) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != pat) same = 1'b0;
            if (same) nb = pat;
        end
        step();
        chk({tag, "_btn"}, 32'(btn1), 32'(nb));
        chk({tag, "_chg"}, 32'(chg1), 32'(nb != m_btn));
        step();
        chk({tag, "_chg_clr"}, 32'(chg1), 32'd0);
        m_btn = nb;
    endtask

    initial begin
        int n, b, l, h, lo, p, t1, t2, k;
        logic pc;
        logic [7:0] rp;

        nres = 1'b0; poll_req = 1'b0;
        repeat (3) step();
        chk("rst_outs", 32'({latch1, jclk1, busy1, done1, chg1, btn1}), 32'd0);

        // Reset release and first automatic poll timing.
        nres = 1'b1;
        wait_latch(n);
        chk("first_latch_cycle", 32'(n), 32'd200);
        measure(b, l, h, lo, p);
        chk("busy_len", 32'(b), 32'd68);
        chk("latch_len", 32'(l), 32'd8);
        chk("clk_pulses", 32'(p), 32'd7);
        chk("clk_high", 32'(h), 32'd28);
        chk("clk_low", 32'(lo), 32'd32);
        poll_check("float", 8'h00);

        // Constant pattern A+Start+Left, then a one-poll glitch.
        poll_check("const1", 8'h49);
        poll_check("const2", 8'h49);
        poll_check("const3", 8'h49);
        poll_check("glitch", 8'h48);
        poll_check("recover", 8'h49);
        chk("glitch_hold", 32'(btn1), 32'h49);

        // Immediate request in IDLE, a second one while busy is dropped.
        repeat (20) step();
        chk("req_idle", 32'(busy1), 32'd0);
        pat1 = 8'h12;
        poll_req = 1'b1; step(); poll_req = 1'b0;
        chk("req_latch", 32'(latch1), 32'd1);
        t1 = cyc;
        repeat (9) step();
        poll_req = 1'b1; step(); poll_req = 1'b0;
        poll_check("req", 8'h12);
        wait_latch(n);
        t2 = cyc;
        chk("req_interval", 32'(t2 - t1), 32'd200);
        poll_check("req_next", 8'h12);

        // Randomized patterns, often repeated so the filter gets to publish.
        rp = 8'h12;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 0) rp = 8'($urandom_range(0, 255));
            poll_check($sformatf("rnd%0d", i), rp);
        end

        // Reset during CLKH of bit 4.
        pat1 = 8'h5A;
        wait_latch(n);
        chk("mid_latch", 32'(latch1), 32'd1);
        k = 0; p = 0; pc = 1'b0;
        while (p < 4 && k < 200) begin
            step(); k++;
            if (jclk1 && !pc) p++;
            pc = jclk1;
        end
        chk("mid_clkh", 32'(jclk1), 32'd1);
        #1 nres = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({jclk1, busy1, latch1, done1, chg1, btn1}), 32'd0);
        step();
        hist.delete();
        m_btn = 8'h00;
        pat1 = 8'h00;
        pat2 = 8'h81;
        nres = 1'b1;
        wait_latch(n);
        chk("restart_latch_cycle", 32'(n), 32'd200);
        measure(b, l, h, lo, p);
        chk("restart_busy_len", 32'(b), 32'd68);

        // FILTER_CNT=1 instance: publishes on the first poll, 2 cycles after final sample.
        chk("f1_done", 32'(done2), 32'd1);
        chk("f1_btn_early", 32'(btn2), 32'd0);
        step();
        chk("f1_btn", 32'(btn2), 32'h81);
        chk("f1_chg", 32'(chg2), 32'd1);
        chk("restart_btn1", 32'(btn1), 32'd0);
        step();
        chk("f1_chg_clr", 32'(chg2), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
